// File: rtl/bcd_elapsed_timer.sv
// BCD elapsed-time counter (mm..m:ss) with a 1 Hz prescaler, count direction,
// saturate-or-wrap limits and a one-step-per-cycle seek engine.
module bcd_elapsed_timer #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned MIN_DIGITS = 2,
    parameter int unsigned STEP_W     = 8,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    count,
    input  logic                    dir,
    input  logic                    seek_req,
    input  logic                    seek_dir,
    input  logic [STEP_W-1:0]       seek_amount,
    output logic                    busy,
    output logic [3:0]              seconds0,
    output logic [3:0]              seconds1,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic                    limit,
    output logic                    at_zero
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned MW = 4 * MIN_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [3:0]        sec0_q, sec0_d, sec0_n;
    logic [3:0]        sec1_q, sec1_d, sec1_n;
    logic [MW-1:0]     min_q, min_d, min_n;
    logic [PW-1:0]     presc_q, presc_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              seek_dir_q, seek_dir_d;
    logic              limit_q, limit_d;

    logic tick, do_step, step_dir, accept, carry;

    assign tick     = count && !busy_q && (presc_q == PRESC_MAX);
    assign do_step  = busy_q || tick;
    assign step_dir = busy_q ? seek_dir_q : dir;
    assign accept   = seek_req && !busy_q && (seek_amount != '0);

    // Single stepper shared by tick and seek; carry out of the top digit marks a limit.
    always_comb begin
        sec0_n = sec0_q;
        sec1_n = sec1_q;
        min_n  = min_q;
        carry  = 1'b1;
        if (!step_dir) begin
            if (sec0_q >= 4'd9) begin
                sec0_n = 4'd0;
            end else begin
                sec0_n = sec0_q + 4'd1;
                carry  = 1'b0;
            end
            if (carry) begin
                if (sec1_q >= 4'd5) begin
                    sec1_n = 4'd0;
                end else begin
                    sec1_n = sec1_q + 4'd1;
                    carry  = 1'b0;
                end
            end
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (carry) begin
                    if (min_q[4*i +: 4] >= 4'd9) begin
                        min_n[4*i +: 4] = 4'd0;
                    end else begin
                        min_n[4*i +: 4] = min_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end else begin
            if (sec0_q == 4'd0) begin
                sec0_n = 4'd9;
            end else begin
                sec0_n = sec0_q - 4'd1;
                carry  = 1'b0;
            end
            if (carry) begin
                if (sec1_q == 4'd0) begin
                    sec1_n = 4'd5;
                end else begin
                    sec1_n = sec1_q - 4'd1;
                    carry  = 1'b0;
                end
            end
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (carry) begin
                    if (min_q[4*i +: 4] == 4'd0) begin
                        min_n[4*i +: 4] = 4'd9;
                    end else begin
                        min_n[4*i +: 4] = min_q[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        presc_d    = presc_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        seek_dir_d = seek_dir_q;
        sec0_d     = sec0_q;
        sec1_d     = sec1_q;
        min_d      = min_q;
        limit_d    = 1'b0;

        if (count && !busy_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == STEP_W'(1)) begin
                busy_d = 1'b0;
            end
        end else if (accept) begin
            busy_d     = 1'b1;
            cnt_d      = seek_amount;
            seek_dir_d = seek_dir;
        end

        if (do_step) begin
            limit_d = carry;
            if (!(SATURATE && carry)) begin
                sec0_d = sec0_n;
                sec1_d = sec1_n;
                min_d  = min_n;
            end
        end

        if (clear) begin
            presc_d    = '0;
            busy_d     = 1'b0;
            cnt_d      = '0;
            seek_dir_d = 1'b0;
            sec0_d     = 4'd0;
            sec1_d     = 4'd0;
            min_d      = '0;
            limit_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            seek_dir_q <= 1'b0;
            sec0_q     <= 4'd0;
            sec1_q     <= 4'd0;
            min_q      <= '0;
            limit_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            seek_dir_q <= seek_dir_d;
            sec0_q     <= sec0_d;
            sec1_q     <= sec1_d;
            min_q      <= min_d;
            limit_q    <= limit_d;
        end
    end

    assign busy     = busy_q;
    assign seconds0 = sec0_q;
    assign seconds1 = sec1_q;
    assign minutes  = min_q;
    assign limit    = limit_q;
    assign at_zero  = (sec0_q == 4'd0) && (sec1_q == 4'd0) && (min_q == '0);

endmodule

// File: tb/tb_bcd_elapsed_timer.sv
// Directed bench: a wrapping 1-minute-digit timer and a saturating 2-digit timer share stimulus.
module tb_bcd_elapsed_timer;

    logic       clk = 1'b0;
    logic       reset, clear, count, dir, seek_req, seek_dir;
    logic [7:0] seek_amount;

    logic       w_busy, w_limit, w_zero;
    logic [3:0] w_s0, w_s1, w_min;
    logic       s_busy, s_limit, s_zero;
    logic [3:0] s_s0, s_s1;
    logic [7:0] s_min;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_elapsed_timer #(.CLK_HZ(4), .MIN_DIGITS(1), .STEP_W(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .count(count), .dir(dir),
        .seek_req(seek_req), .seek_dir(seek_dir), .seek_amount(seek_amount),
        .busy(w_busy), .seconds0(w_s0), .seconds1(w_s1), .minutes(w_min),
        .limit(w_limit), .at_zero(w_zero)
    );

    bcd_elapsed_timer #(.CLK_HZ(4), .MIN_DIGITS(2), .STEP_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .count(count), .dir(dir),
        .seek_req(seek_req), .seek_dir(seek_dir), .seek_amount(seek_amount),
        .busy(s_busy), .seconds0(s_s0), .seconds1(s_s1), .minutes(s_min),
        .limit(s_limit), .at_zero(s_zero)
    );

    function automatic logic [31:0] wt();
        return {20'd0, w_min, w_s1, w_s0};
    endfunction

    function automatic logic [31:0] st();
        return {16'd0, s_min, s_s1, s_s0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        clear = 1'b1;
        cycle(1);
        clear = 1'b0;
    endtask

    task automatic do_seek(input logic d, input logic [7:0] amt);
        seek_req    = 1'b1;
        seek_dir    = d;
        seek_amount = amt;
        cycle(1);
        seek_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((w_busy || s_busy) && n < 500) begin
            n++;
            cycle(1);
        end
        check_eq("idle", {30'd0, w_busy, s_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nl, nlw;
        reset = 1'b0; clear = 1'b0; count = 1'b0; dir = 1'b0;
        seek_req = 1'b0; seek_dir = 1'b0; seek_amount = 8'd0;
        cycle(2);
        check_eq("rst_time_w", wt(), 32'h000);
        check_eq("rst_time_s", st(), 32'h0000);
        check_eq("rst_flags", {28'd0, w_busy, w_limit, s_busy, s_limit}, 32'd0);
        check_eq("rst_zero", {30'd0, w_zero, s_zero}, 32'd3);
        reset = 1'b1;

        // Reset mid-operation
        count = 1'b1;
        cycle(13);
        check_eq("run13_w", wt(), 32'h003);
        #2 reset = 1'b0; count = 1'b0;
        #1;
        check_eq("async_rst_w", wt(), 32'h000);
        check_eq("async_rst_s", st(), 32'h0000);
        check_eq("async_rst_zero", {30'd0, w_zero, s_zero}, 32'd3);
        cycle(1);
        reset = 1'b1;
        cycle(1);
        count = 1'b1;
        cycle(3);
        check_eq("first_tick_pre", wt(), 32'h000);
        cycle(1);
        check_eq("first_tick", wt(), 32'h001);
        count = 1'b0;

        // Up count and pause
        clear_all();
        count = 1'b1;
        cycle(40);
        check_eq("up40_w", wt(), 32'h010);
        check_eq("up40_s", st(), 32'h0010);
        count = 1'b0;
        cycle(21);
        check_eq("pause", wt(), 32'h010);
        count = 1'b1;
        cycle(3);
        check_eq("presc_frozen", wt(), 32'h010);
        cycle(1);
        check_eq("resume_tick", wt(), 32'h011);
        count = 1'b0;

        // Carry through seek
        clear_all();
        do_seek(1'b0, 8'd59);
        nb = 0;
        while (w_busy && nb < 300) begin
            nb++;
            cycle(1);
        end
        check_eq("seek59_busy", nb, 59);
        check_eq("seek59_w", wt(), 32'h059);
        count = 1'b1;
        cycle(4);
        count = 1'b0;
        check_eq("carry_min_w", wt(), 32'h100);
        check_eq("carry_min_s", st(), 32'h0100);

        // Wrap at the limits
        clear_all();
        do_seek(1'b1, 8'd1);
        cycle(1);
        check_eq("wrap_dn_w", wt(), 32'h959);
        check_eq("wrap_dn_lim", {31'd0, w_limit}, 32'd1);
        check_eq("sat_dn_s", st(), 32'h0000);
        check_eq("sat_dn_lim", {31'd0, s_limit}, 32'd1);
        cycle(1);
        check_eq("lim_pulse", {30'd0, w_limit, s_limit}, 32'd0);
        dir = 1'b0; count = 1'b1;
        cycle(4);
        check_eq("wrap_up_w", wt(), 32'h000);
        check_eq("wrap_up_lim", {31'd0, w_limit}, 32'd1);
        dir = 1'b1;
        cycle(1);
        check_eq("wrap_up_lim_end", {31'd0, w_limit}, 32'd0);
        cycle(3);
        check_eq("wrap_tick_dn_w", wt(), 32'h959);
        check_eq("wrap_tick_dn_lim", {31'd0, w_limit}, 32'd1);
        count = 1'b0; dir = 1'b0;

        // Saturate down
        clear_all();
        do_seek(1'b0, 8'd3);
        wait_idle();
        check_eq("pre_sat_s", st(), 32'h0003);
        do_seek(1'b1, 8'd10);
        nb = 0; nl = 0; nlw = 0;
        for (int i = 0; i < 14; i++) begin
            nb  += int'(s_busy);
            nl  += int'(s_limit);
            nlw += int'(w_limit);
            cycle(1);
        end
        check_eq("sat_busy_cyc", nb, 10);
        check_eq("sat_lim_cyc", nl, 7);
        check_eq("sat_final_s", st(), 32'h0000);
        check_eq("sat_zero", {31'd0, s_zero}, 32'd1);
        check_eq("wrapseek_w", wt(), 32'h953);
        check_eq("wrapseek_lim_cyc", nlw, 1);

        // Busy protection and clear abort
        clear_all();
        do_seek(1'b0, 8'd5);
        do_seek(1'b0, 8'd100);
        wait_idle();
        check_eq("no_queue_s", st(), 32'h0005);
        clear_all();
        do_seek(1'b0, 8'd20);
        cycle(2);
        clear = 1'b1;
        cycle(1);
        clear = 1'b0;
        check_eq("abort_time", st(), 32'h0000);
        check_eq("abort_busy", {30'd0, w_busy, s_busy}, 32'd0);
        cycle(5);
        check_eq("abort_hold", st(), 32'h0000);

        // Seek request coincident with clear is dropped; zero amount is a no-op
        clear = 1'b1;
        do_seek(1'b0, 8'd5);
        clear = 1'b0;
        check_eq("clear_drop_busy", {30'd0, w_busy, s_busy}, 32'd0);
        do_seek(1'b0, 8'd0);
        check_eq("zero_amt_busy", {30'd0, w_busy, s_busy}, 32'd0);
        cycle(1);
        check_eq("zero_amt_time", st(), 32'h0000);

        // Tick on the acceptance edge applies; prescaler holds while busy
        clear_all();
        count = 1'b1;
        cycle(3);
        do_seek(1'b0, 8'd2);
        check_eq("accept_tick_s", st(), 32'h0001);
        check_eq("accept_busy", {31'd0, s_busy}, 32'd1);
        cycle(2);
        check_eq("seek2_s", st(), 32'h0003);
        check_eq("seek2_busy", {31'd0, s_busy}, 32'd0);
        cycle(3);
        check_eq("busy_hold_presc", st(), 32'h0003);
        cycle(1);
        check_eq("post_seek_tick", st(), 32'h0004);
        count = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
